uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter BAUD_DIV, default 434, clock cycles per bit (50 MHz / 115200); legal range 4..65535.
REQ-002 clock  input  1  single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 rx  input  1  serial line, idle high, 8N1 framing, LSB first; asynchronous to clock.
REQ-005 data  output  8  received byte; holds its value while valid is high.
REQ-006 valid  output  1  data holds an unconsumed byte.
REQ-007 ready  input  1  consumer accepts data on a cycle where valid and ready are both high.
REQ-008 frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-009 overrun  output  1  one-cycle pulse: byte completed while the buffer was full.

Function
REQ-010 rx SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value rxs.
REQ-011 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE, plus a bit counter (0..7) and a baud counter of ceil(log2(BAUD_DIV)) bits.
REQ-012 In IDLE, when rxs==0, the FSM SHALL go to START and load the baud counter with BAUD_DIV/2-1 (integer division).
REQ-013 The baud counter SHALL decrement every cycle outside IDLE; "expiry" means the counter equals 0.
REQ-014 At START expiry, if rxs==0 the FSM SHALL go to DATA with baud counter BAUD_DIV-1 and bit counter 0; otherwise it SHALL go to IDLE, treating the start as a glitch, with no output activity.
REQ-015 At each DATA expiry the FSM SHALL shift rxs into the MSB of a shift register (right shift, LSB first on the wire) and reload BAUD_DIV-1.
REQ-016 After the 8th DATA sample the FSM SHALL go to STOP.
REQ-017 At STOP expiry, if rxs==1 the byte SHALL be delivered per REQ-019 and the FSM SHALL go to IDLE.
REQ-018 At STOP expiry, if rxs==0, frame_err SHALL pulse for one cycle, the byte SHALL be discarded, and the FSM SHALL go to WAIT_IDLE; WAIT_IDLE SHALL go to IDLE on the first cycle rxs==1 (break handling).
REQ-019 Delivery when the buffer is free, or freed in the same cycle (valid&&ready): data SHALL load the shift register and valid SHALL be 1 in the next cycle.
REQ-020 Delivery when valid==1 and ready==0: overrun SHALL pulse for one cycle, the new byte SHALL be dropped, and data/valid SHALL be unchanged.
REQ-021 When valid&&ready with no simultaneous delivery, valid SHALL clear in the next cycle.
REQ-022 Latency: valid SHALL rise exactly 1 cycle after the STOP sample cycle, which is nominally 9.5*BAUD_DIV + 3 cycles after the rx falling edge.
REQ-023 frame_err and overrun SHALL never be high for more than one consecutive cycle per event, and SHALL never both be high in the same cycle.

Reset
REQ-024 Reset SHALL force: FSM=IDLE, synchronizer flops=1, shift register=0, data=0x00, valid=0, frame_err=0, overrun=0, counters=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no delivery or error pulse.
REQ-026 After reset release, a line held low SHALL be treated as a new start bit.

Verification (BAUD_DIV=8 unless noted)
REQ-027 Send 0x55, ready=1 -> data=0x55, valid high for exactly 1 cycle, occurring 79 cycles after the falling edge; frame_err=0 and overrun=0.
REQ-028 Drive a 3-cycle low glitch on idle rx -> no valid, no frame_err; a following byte 0xA3 is received correctly.
REQ-029 Send 0x0F with the stop bit low, then hold rx low 40 cycles -> one frame_err pulse, valid stays 0, FSM stays in WAIT_IDLE until rx rises; next byte 0x3C is received.
REQ-030 ready=0, send 0x12 then 0x34 -> data=0x12 held, one overrun pulse; raise ready -> 0x12 consumed, valid drops.
REQ-031 ready=1 on the exact delivery cycle while 0x12 is still pending -> 0x12 consumed, 0x34 loaded, no overrun.
REQ-032 Assert reset at bit 4 of a frame, release, send 0x81 with BAUD_DIV=434 -> only 0x81 delivered, no error pulses.

Source files
------------

// File: rtl/uart_rx.sv
// ----------------------------------------------------------------------------
// uart_rx -- 8N1 UART receiver with a one-entry output buffer.
//
// The serial line is brought into the clock domain through a two-flop
// synchroniser. A start bit is qualified at its midpoint, each data bit is
// sampled at its midpoint (LSB first), and the stop bit decides between
// delivering the byte and reporting a framing error. A stop bit sampled low
// parks the receiver until the line returns high, so a break condition
// cannot be mistaken for a stream of new start bits.
//
// Ports
//   clock_i      : single clock, rising-edge active
//   reset_i      : asynchronous, active-high reset
//   rx_i         : serial line, idle high, asynchronous to clock_i
//   ready_i      : consumer takes data_o on a cycle with valid_o && ready_i
//   data_o[7:0]  : received byte, stable while valid_o is high
//   valid_o      : data_o holds an unconsumed byte
//   frame_err_o  : one-cycle pulse, stop bit sampled low (byte discarded)
//   overrun_o    : one-cycle pulse, byte completed while buffer was full
// ----------------------------------------------------------------------------
module uart_rx #(
    parameter int BAUD_DIV = 434    // clock cycles per bit, 4..65535
) (
    input  logic       clock_i,
    input  logic       reset_i,
    input  logic       rx_i,
    input  logic       ready_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       frame_err_o,
    output logic       overrun_o
);

    localparam int CW = $clog2(BAUD_DIV);
    // First reload lands mid start bit; later reloads step a full bit.
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_IDLE
    } state_e;

    logic [1:0]    sync_q;
    logic          rxs;
    state_e        state_q, state_d;
    logic [CW-1:0] baud_q, baud_d;
    logic [2:0]    bit_q, bit_d;
    logic [7:0]    shift_q, shift_d;
    logic [7:0]    data_q, data_d;
    logic          valid_q, valid_d;
    logic          ferr_q, ferr_d;
    logic          ovr_q, ovr_d;
    logic          expired;
    logic          deliver;

    // Synchroniser resets to the idle level so reset itself never looks
    // like a falling edge.
    // NOTE: sequential blocks use non-blocking assignments so every flop
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], rx_i};
        end
    end

    assign rxs     = sync_q[1];
    assign expired = (baud_q == '0);

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            ferr_q  <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            ferr_q  <= ferr_d;
            ovr_q   <= ovr_d;
        end
    end

    // NOTE: every signal written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = (state_q == S_IDLE) ? baud_q : baud_q - CW'(1);
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        ferr_d  = 1'b0;
        ovr_d   = 1'b0;
        deliver = 1'b0;

        if (valid_q && ready_i) begin
            valid_d = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (!rxs) begin
                    state_d = S_START;
                    baud_d  = HALF_LOAD;
                end
            end
            S_START: begin
                if (expired) begin
                    if (!rxs) begin
                        state_d = S_DATA;
                        baud_d  = FULL_LOAD;
                        bit_d   = '0;
                    end else begin
                        // Line back high at mid start bit: a glitch.
                        state_d = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (expired) begin
                    shift_d = {rxs, shift_q[7:1]};
                    baud_d  = FULL_LOAD;
                    if (bit_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_d = bit_q + 3'd1;
                    end
                end
            end
            S_STOP: begin
                if (expired) begin
                    if (rxs) begin
                        deliver = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = S_WAIT_IDLE;
                    end
                end
            end
            S_WAIT_IDLE: begin
                if (rxs) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // A byte may land in a buffer that is being drained this same cycle.
        if (deliver) begin
            if (!valid_q || ready_i) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                ovr_d = 1'b1;
            end
        end
    end

    assign data_o      = data_q;
    assign valid_o     = valid_q;
    assign frame_err_o = ferr_q;
    assign overrun_o   = ovr_q;

endmodule

// File: tb/tb_uart_rx.sv
// ----------------------------------------------------------------------------
// tb_uart_rx -- self-checking bench for uart_rx.
// Instance u_fast runs BAUD_DIV=8 for most scenarios; u_slow runs the
// default 434 for the reset-abort scenario. Frames are driven one bit per
// BAUD_DIV cycles starting #1 after a rising edge; outputs are sampled #1
// after a rising edge or counted on the falling edge.
// ----------------------------------------------------------------------------
module tb_uart_rx;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, rx, ready;
    logic [7:0] data;
    logic       valid, ferr, ovr;

    logic       rst_s, rx_s, ready_s;
    logic [7:0] data_s;
    logic       valid_s, ferr_s, ovr_s;

    uart_rx #(.BAUD_DIV(8)) u_fast (
        .clock_i     (clk),
        .reset_i     (rst),
        .rx_i        (rx),
        .ready_i     (ready),
        .data_o      (data),
        .valid_o     (valid),
        .frame_err_o (ferr),
        .overrun_o   (ovr)
    );

    uart_rx #(.BAUD_DIV(434)) u_slow (
        .clock_i     (clk),
        .reset_i     (rst_s),
        .rx_i        (rx_s),
        .ready_i     (ready_s),
        .data_o      (data_s),
        .valid_o     (valid_s),
        .frame_err_o (ferr_s),
        .overrun_o   (ovr_s)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    // Event counters, owned by this monitor only.
    int         v_cnt = 0, fe_cnt = 0, ov_cnt = 0;
    int         vs_cnt = 0, fes_cnt = 0, ovs_cnt = 0;
    int         both_cnt = 0, rep_cnt = 0;
    logic [7:0] last_data = '0, last_data_s = '0;
    logic       fe_prev = 1'b0, ov_prev = 1'b0, fes_prev = 1'b0, ovs_prev = 1'b0;

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            v_cnt     <= v_cnt + 1;
            last_data <= data;
        end
        if (valid_s === 1'b1) begin
            vs_cnt      <= vs_cnt + 1;
            last_data_s <= data_s;
        end
        if (ferr === 1'b1)   fe_cnt  <= fe_cnt + 1;
        if (ovr === 1'b1)    ov_cnt  <= ov_cnt + 1;
        if (ferr_s === 1'b1) fes_cnt <= fes_cnt + 1;
        if (ovr_s === 1'b1)  ovs_cnt <= ovs_cnt + 1;
        if ((ferr === 1'b1 && ovr === 1'b1) || (ferr_s === 1'b1 && ovr_s === 1'b1))
            both_cnt <= both_cnt + 1;
        if ((ferr === 1'b1 && fe_prev) || (ovr === 1'b1 && ov_prev) ||
            (ferr_s === 1'b1 && fes_prev) || (ovs_prev && ovr_s === 1'b1))
            rep_cnt <= rep_cnt + 1;
        fe_prev  <= (ferr === 1'b1);
        ov_prev  <= (ovr === 1'b1);
        fes_prev <= (ferr_s === 1'b1);
        ovs_prev <= (ovr_s === 1'b1);
    end

    int first_valid;

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Drives start, 8 data bits (LSB first) and stop. Records the cycle
    // (counted from the start-bit drive) at which valid is first seen.
    // ready_at >= 0 raises fast ready for exactly the edge after that cycle.
    // abort_bit >= 0 asserts reset when that bit position would begin.
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int div,
                              input bit slow, input int ready_at, input int abort_bit);
        logic [9:0] bits;
        int         cyc;
        bits        = {stop_bit, b, 1'b0};
        cyc         = 0;
        first_valid = -1;
        for (int i = 0; i < 10; i++) begin
            if (i == abort_bit) begin
                if (slow) begin rst_s = 1'b1; rx_s = 1'b1; end
                else      begin rst   = 1'b1; rx   = 1'b1; end
                idle(3);
                if (slow) rst_s = 1'b0;
                else      rst   = 1'b0;
                return;
            end
            if (slow) rx_s = bits[i];
            else      rx   = bits[i];
            repeat (div) begin
                @(posedge clk);
                #1;
                cyc++;
                if (((slow ? valid_s : valid) === 1'b1) && first_valid < 0)
                    first_valid = cyc;
                if (cyc == ready_at)
                    ready = 1'b1;
                else if (ready_at >= 0 && cyc == ready_at + 1)
                    ready = 1'b0;
            end
        end
    endtask

    typedef struct {
        logic [7:0] b;
        logic       stop;
        int         exp_vcyc;
        int         exp_fe;
        int         exp_lat;
    } vec_t;

    vec_t vecs[8];

    initial begin
        int v0, f0, o0;

        vecs[0] = '{8'h55, 1'b1, 1, 0, 79};
        vecs[1] = '{8'h00, 1'b1, 1, 0, 79};
        vecs[2] = '{8'hFF, 1'b1, 1, 0, 79};
        vecs[3] = '{8'hA3, 1'b1, 1, 0, 79};
        vecs[4] = '{8'h0F, 1'b0, 0, 1, -1};
        vecs[5] = '{8'h3C, 1'b1, 1, 0, 79};
        vecs[6] = '{8'h80, 1'b1, 1, 0, 79};
        vecs[7] = '{8'h01, 1'b1, 1, 0, 79};

        rst = 1'b1; rx = 1'b1; ready = 1'b1;
        rst_s = 1'b1; rx_s = 1'b1; ready_s = 1'b1;
        idle(3);
        check("reset data",      32'(data),    32'h00);
        check("reset valid",     32'(valid),   32'd0);
        check("reset frame_err", 32'(ferr),    32'd0);
        check("reset overrun",   32'(ovr),     32'd0);
        check("reset data slow", 32'(data_s),  32'h00);
        check("reset valid slow",32'(valid_s), 32'd0);
        rst = 1'b0; rst_s = 1'b0;
        idle(3);

        // Table: back-to-back frames with ready held high.
        for (int i = 0; i < 8; i++) begin
            v0 = v_cnt; f0 = fe_cnt; o0 = ov_cnt;
            send_frame(vecs[i].b, vecs[i].stop, 8, 1'b0, -1, -1);
            rx = 1'b1;
            idle(4);
            check($sformatf("vec%0d valid cycles", i), 32'(v_cnt - v0),  32'(vecs[i].exp_vcyc));
            check($sformatf("vec%0d frame_err", i),    32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
            check($sformatf("vec%0d overrun", i),      32'(ov_cnt - o0), 32'd0);
            check($sformatf("vec%0d latency", i),      32'(first_valid), 32'(vecs[i].exp_lat));
            if (vecs[i].exp_vcyc > 0)
                check($sformatf("vec%0d data", i), 32'(last_data), 32'(vecs[i].b));
        end

        // Three-cycle glitch is rejected, then a real byte follows.
        v0 = v_cnt; f0 = fe_cnt;
        rx = 1'b0;
        idle(3);
        rx = 1'b1;
        idle(20);
        check("glitch valid",     32'(v_cnt - v0),  32'd0);
        check("glitch frame_err", 32'(fe_cnt - f0), 32'd0);
        send_frame(8'hA3, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("post-glitch data",  32'(last_data),   32'hA3);
        check("post-glitch valid", 32'(v_cnt - v0),  32'd1);
        check("post-glitch lat",   32'(first_valid), 32'd79);

        // Break: stop low then line held low; one error, then recovery.
        v0 = v_cnt; f0 = fe_cnt;
        send_frame(8'h0F, 1'b0, 8, 1'b0, -1, -1);
        idle(40);
        check("break frame_err", 32'(fe_cnt - f0), 32'd1);
        check("break valid",     32'(v_cnt - v0),  32'd0);
        rx = 1'b1;
        idle(4);
        send_frame(8'h3C, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("after break data",      32'(last_data),   32'h3C);
        check("after break valid",     32'(v_cnt - v0),  32'd1);
        check("after break frame_err", 32'(fe_cnt - f0), 32'd1);

        // Overrun: buffer full, second byte dropped.
        ready = 1'b0;
        o0 = ov_cnt;
        send_frame(8'h12, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("ovr first valid", 32'(valid), 32'd1);
        check("ovr first data",  32'(data),  32'h12);
        send_frame(8'h34, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("ovr pulse",      32'(ov_cnt - o0), 32'd1);
        check("ovr held data",  32'(data),        32'h12);
        check("ovr held valid", 32'(valid),       32'd1);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        check("ovr consumed valid", 32'(valid), 32'd0);

        // Consume on the exact delivery edge: no overrun, new byte loaded.
        send_frame(8'h12, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("same-cycle pending", 32'(valid), 32'd1);
        o0 = ov_cnt;
        send_frame(8'h34, 1'b1, 8, 1'b0, 78, -1);
        rx = 1'b1;
        idle(4);
        check("same-cycle data",    32'(data),        32'h34);
        check("same-cycle valid",   32'(valid),       32'd1);
        check("same-cycle overrun", 32'(ov_cnt - o0), 32'd0);
        ready = 1'b1;
        idle(1);
        check("same-cycle drained", 32'(valid), 32'd0);

        // Line already low when reset releases counts as a start bit.
        v0 = v_cnt; f0 = fe_cnt;
        rst = 1'b1; rx = 1'b0;
        idle(3);
        rst = 1'b0;
        send_frame(8'hC5, 1'b1, 8, 1'b0, -1, -1);
        rx = 1'b1;
        idle(4);
        check("low-at-release data",    32'(last_data),   32'hC5);
        check("low-at-release valid",   32'(v_cnt - v0),  32'd1);
        check("low-at-release latency", 32'(first_valid), 32'd79);
        check("low-at-release ferr",    32'(fe_cnt - f0), 32'd0);

        // BAUD_DIV=434: reset at data bit 4 aborts cleanly, 0x81 follows.
        v0 = vs_cnt; f0 = fes_cnt; o0 = ovs_cnt;
        send_frame(8'hF0, 1'b1, 434, 1'b1, -1, 5);
        idle(10);
        check("abort no valid", 32'(vs_cnt - v0), 32'd0);
        send_frame(8'h81, 1'b1, 434, 1'b1, -1, -1);
        rx_s = 1'b1;
        idle(4);
        check("slow data",      32'(last_data_s),  32'h81);
        check("slow valid",     32'(vs_cnt - v0),  32'd1);
        check("slow latency",   32'(first_valid),  32'd4126);
        check("slow frame_err", 32'(fes_cnt - f0), 32'd0);
        check("slow overrun",   32'(ovs_cnt - o0), 32'd0);

        check("error pulses never coincide", 32'(both_cnt), 32'd0);
        check("error pulses one cycle",      32'(rep_cnt),  32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
